axi_ddr_slave_model: RTL and testbench

- AXI4 slave (responder) that is the far end of the core's DDR master port: 27-bit byte address, 128-bit data.
- Backed by an on-chip 128-bit-wide memory array.
- Stands in for the MIG/DDR controller in simulation and in BRAM-only FPGA builds.
- Independent read and write engines, one outstanding transaction each, INCR bursts only.

---
 rtl/axi_ddr_slave_model_if.sv | 53 +++++
 rtl/axi_ddr_slave_model.sv | 200 ++++++++++++++++++++
 tb/tb_axi_ddr_slave_model.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_ddr_slave_model_if.sv
// AXI4 bundle between the core's DDR master port and the memory model.
// Only the signals the model uses are carried. SIZE is fixed at 16 bytes,
// BURST is always INCR, and LOCK/CACHE/PROT/QOS are not present.
//   slave  modport : the responder side (axi_ddr_slave_model)
//   master modport : the requester side (core or testbench)
interface axi_ddr_slave_model_if #(
    parameter int ADDR_W = 27,
    parameter int DATA_W = 128
);
    localparam int STRB_W = DATA_W / 8;

    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic              awvalid;
    logic              awready;

    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;

    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic              arvalid;
    logic              arready;

    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport slave (
        input  awaddr, awlen, awvalid, output awready,
        input  wdata, wstrb, wlast, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arlen, arvalid, output arready,
        output rdata, rresp, rlast, rvalid, input rready
    );

    modport master (
        output awaddr, awlen, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arlen, arvalid, input arready,
        input  rdata, rresp, rlast, rvalid, output rready
    );
endinterface

// File: rtl/axi_ddr_slave_model.sv
// AXI4 INCR-burst slave backed by an on-chip 128-bit memory. It stands in
// for the DDR controller in simulation and in BRAM-only FPGA builds.
// The read and write engines are independent, and each has one burst in
// flight at a time.
//   clk   : system clock
//   rst   : asynchronous, active-low reset (memory contents are kept)
//   s_axi : slave modport of axi_ddr_slave_model_if (AW/W/B/AR/R channels)
// Word index = addr[DEPTH_LOG2+3:4]. Higher address bits are ignored, so
// addresses alias, and bursts wrap at the top of the array.
module axi_ddr_slave_model #(
    parameter int ADDR_W     = 27,
    parameter int DATA_W     = 128,
    parameter int DEPTH_LOG2 = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    axi_ddr_slave_model_if.slave  s_axi
);
    localparam int STRB_W = DATA_W / 8;
    localparam int DEPTH  = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_e;
    typedef logic [DEPTH_LOG2-1:0] word_addr_t;

    logic [DATA_W-1:0] mem [DEPTH];

    // live_q holds the READY outputs low while in reset and until the
    // first clock edge after release.
    logic       live_q;
    w_state_e   w_state_q, w_state_d;
    word_addr_t w_addr_q,  w_addr_d;
    logic [7:0] w_len_q,   w_len_d;
    logic [7:0] w_cnt_q,   w_cnt_d;
    logic       w_err_q,   w_err_d;
    r_state_e   r_state_q, r_state_d;
    word_addr_t r_addr_q,  r_addr_d;
    logic [7:0] r_len_q,   r_len_d;
    logic [7:0] r_cnt_q,   r_cnt_d;
    logic [DATA_W-1:0] rdata_q;

    logic       aw_ready, w_ready, b_valid, ar_ready, r_valid, r_last;
    logic [1:0] b_resp;
    logic       aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic       w_final, r_final;
    logic       rd_en;
    word_addr_t rd_addr;

    assign aw_hs   = s_axi.awvalid & aw_ready;
    assign w_hs    = s_axi.wvalid  & w_ready;
    assign b_hs    = s_axi.bready  & b_valid;
    assign ar_hs   = s_axi.arvalid & ar_ready;
    assign r_hs    = s_axi.rready  & r_valid;
    assign w_final = (w_cnt_q == w_len_q);
    assign r_final = (r_cnt_q == r_len_q);

    // ---------------- state registers ----------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            live_q    <= 1'b0;
            w_state_q <= W_IDLE;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_err_q   <= 1'b0;
            r_state_q <= R_IDLE;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
        end else begin
            live_q    <= 1'b1;
            w_state_q <= w_state_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
            w_err_q   <= w_err_d;
            r_state_q <= r_state_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
        end
    end

    // ---------------- write engine: next state ----------------
    // NOTE: each comb output gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        w_state_d = w_state_q;
        w_addr_d  = w_addr_q;
        w_len_d   = w_len_q;
        w_cnt_d   = w_cnt_q;
        w_err_d   = w_err_q;
        case (w_state_q)
            W_IDLE: if (aw_hs) begin
                w_addr_d  = s_axi.awaddr[DEPTH_LOG2+3:4];
                w_len_d   = s_axi.awlen;
                w_cnt_d   = '0;
                w_state_d = W_DATA;
            end
            W_DATA: if (w_hs) begin
                w_addr_d = w_addr_q + word_addr_t'(1);
                w_cnt_d  = w_cnt_q + 8'd1;
                // The beat count alone decides the burst length. A WLAST
                // on the wrong beat is only recorded as an error.
                if (s_axi.wlast != w_final) w_err_d = 1'b1;
                if (w_final) w_state_d = W_RESP;
            end
            W_RESP: if (b_hs) begin
                w_err_d   = 1'b0;
                w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // ---------------- write engine: outputs ----------------
    always_comb begin
        aw_ready = live_q && (w_state_q == W_IDLE);
        w_ready  = (w_state_q == W_DATA);
        b_valid  = (w_state_q == W_RESP);
        b_resp   = (b_valid && w_err_q) ? 2'b10 : 2'b00;
    end

    // ---------------- read engine: next state ----------------
    // The memory read port is registered. rd_en/rd_addr load rdata_q on the
    // AR handshake and on every non-final R handshake. rdata_q therefore
    // holds its value through stalls.
    always_comb begin
        r_state_d = r_state_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        rd_en     = 1'b0;
        rd_addr   = r_addr_q;
        case (r_state_q)
            R_IDLE: if (ar_hs) begin
                r_addr_d  = s_axi.araddr[DEPTH_LOG2+3:4];
                r_len_d   = s_axi.arlen;
                r_cnt_d   = '0;
                rd_en     = 1'b1;
                rd_addr   = s_axi.araddr[DEPTH_LOG2+3:4];
                r_state_d = R_FETCH;
            end
            R_FETCH: r_state_d = R_DATA;
            R_DATA: if (r_hs) begin
                if (r_final) begin
                    r_state_d = R_IDLE;
                end else begin
                    r_addr_d = r_addr_q + word_addr_t'(1);
                    r_cnt_d  = r_cnt_q + 8'd1;
                    rd_en    = 1'b1;
                    rd_addr  = r_addr_q + word_addr_t'(1);
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // ---------------- read engine: outputs ----------------
    always_comb begin
        ar_ready = live_q && (r_state_q == R_IDLE);
        r_valid  = (r_state_q == R_DATA);
        r_last   = r_valid && r_final;
    end

    // ---------------- memory ----------------
    // NOTE: the array has no reset. It models DDR/BRAM contents, which must
    // survive rst, and a reset would prevent RAM inference.
    always_ff @(posedge clk) begin
        if (w_hs) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (s_axi.wstrb[i]) mem[w_addr_q][8*i +: 8] <= s_axi.wdata[8*i +: 8];
            end
        end
    end

    // Non-blocking update semantics make a same-cycle read of a word being
    // written return the old contents (read-first).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       rdata_q <= '0;
        else if (rd_en) rdata_q <= mem[rd_addr];
    end

    assign s_axi.awready = aw_ready;
    assign s_axi.wready  = w_ready;
    assign s_axi.bvalid  = b_valid;
    assign s_axi.bresp   = b_resp;
    assign s_axi.arready = ar_ready;
    assign s_axi.rvalid  = r_valid;
    assign s_axi.rlast   = r_last;
    assign s_axi.rresp   = 2'b00;
    assign s_axi.rdata   = rdata_q;

    // Byte-offset bits and aliased high address bits are ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_axi.awaddr[ADDR_W-1:DEPTH_LOG2+4], s_axi.awaddr[3:0],
                                s_axi.araddr[ADDR_W-1:DEPTH_LOG2+4], s_axi.araddr[3:0]};
endmodule

// File: tb/tb_axi_ddr_slave_model.sv
// Self-checking bench for axi_ddr_slave_model. Read bursts push their
// expected beats, taken from a reference memory model, into a scoreboard
// queue. The beats are popped as the DUT presents them.
module tb_axi_ddr_slave_model;
    localparam int ADDR_W     = 27;
    localparam int DATA_W     = 128;
    localparam int DEPTH_LOG2 = 14;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    typedef struct {
        logic [127:0] data;
        logic         last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    logic [127:0] model_mem [DEPTH];
    logic [127:0] wbeat     [256];
    logic [15:0]  wstrb_arr [256];
    beat_t        exp_q [$];

    axi_ddr_slave_model_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    axi_ddr_slave_model #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk   (clk),
        .rst   (rst),
        .s_axi (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_beats(input int len, input logic [31:0] seed);
        for (int b = 0; b <= len; b++) begin
            wbeat[b]     = {seed + 32'(b), ~(seed + 32'(b)), seed ^ 32'h5A5A_0000, 32'(b)};
            wstrb_arr[b] = 16'hFFFF;
        end
    endtask

    // bad_last >= 0: WLAST is driven only on that beat index. bad_last < 0:
    // WLAST is driven correctly on the last beat.
    task automatic axi_write(input logic [26:0] addr, input int len, input int bad_last,
                             input int b_delay, input logic [1:0] exp_resp, input string name);
        int t;
        int base;
        int word;
        base = int'(addr >> 4) % DEPTH;
        bus.awaddr  = addr;
        bus.awlen   = len[7:0];
        bus.awvalid = 1'b1;
        t = 0;
        while (!bus.awready && t < 50) begin tick(); t++; end
        checks++;
        if (bus.awready !== 1'b1) begin
            errors++;
            $display("FAIL %s aw_handshake: awready=%b required 1", name, bus.awready);
        end
        tick();
        bus.awvalid = 1'b0;
        for (int b = 0; b <= len; b++) begin
            bus.wdata  = wbeat[b];
            bus.wstrb  = wstrb_arr[b];
            bus.wlast  = (bad_last >= 0) ? (b == bad_last) : (b == len);
            bus.wvalid = 1'b1;
            t = 0;
            while (!bus.wready && t < 50) begin tick(); t++; end
            if (bus.wready !== 1'b1) begin
                checks++;
                errors++;
                $display("FAIL %s w_beat%0d: wready=%b required 1", name, b, bus.wready);
            end
            word = (base + b) % DEPTH;
            for (int i = 0; i < 16; i++)
                if (wstrb_arr[b][i]) model_mem[word][8*i +: 8] = wbeat[b][8*i +: 8];
            tick();
        end
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
        checks++;
        if (bus.wready !== 1'b0) begin
            errors++;
            $display("FAIL %s burst_len: wready=%b required 0 after %0d beats", name, bus.wready, len + 1);
        end
        bus.bready = 1'b0;
        for (int i = 0; i < b_delay; i++) begin
            checks++;
            if (bus.bvalid !== 1'b1 || bus.awready !== 1'b0) begin
                errors++;
                $display("FAIL %s b_stall%0d: bvalid=%b awready=%b required 1/0", name, i, bus.bvalid, bus.awready);
            end
            tick();
        end
        checks++;
        if (bus.bvalid !== 1'b1 || bus.bresp !== exp_resp) begin
            errors++;
            $display("FAIL %s bresp: bvalid=%b bresp=%b required 1/%b", name, bus.bvalid, bus.bresp, exp_resp);
        end
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        checks++;
        if (bus.bvalid !== 1'b0 || bus.awready !== 1'b1) begin
            errors++;
            $display("FAIL %s b_done: bvalid=%b awready=%b required 0/1", name, bus.bvalid, bus.awready);
        end
    endtask

    // mode 0: RREADY held high. mode 1: RREADY pattern 1,0,0,1,0,0,...
    // abort_after >= 0: return with that many beats taken, burst still open.
    task automatic axi_read(input logic [26:0] addr, input int len, input int mode,
                            input int abort_after, input string name);
        int    t;
        int    cyc;
        int    got;
        int    base;
        logic  held_v;
        logic [127:0] held;
        beat_t e;
        base = int'(addr >> 4) % DEPTH;
        for (int b = 0; b <= len; b++) begin
            e.data = model_mem[(base + b) % DEPTH];
            e.last = (b == len);
            exp_q.push_back(e);
        end
        bus.araddr  = addr;
        bus.arlen   = len[7:0];
        bus.arvalid = 1'b1;
        t = 0;
        while (!bus.arready && t < 50) begin tick(); t++; end
        checks++;
        if (bus.arready !== 1'b1) begin
            errors++;
            $display("FAIL %s ar_handshake: arready=%b required 1", name, bus.arready);
        end
        tick();
        bus.arvalid = 1'b0;
        checks++;
        if (bus.rvalid !== 1'b0) begin
            errors++;
            $display("FAIL %s rvalid_fetch: rvalid=%b required 0", name, bus.rvalid);
        end
        tick();
        checks++;
        if (bus.rvalid !== 1'b1) begin
            errors++;
            $display("FAIL %s rvalid_latency: rvalid=%b required 1", name, bus.rvalid);
        end
        cyc = 0;
        got = 0;
        held_v = 1'b0;
        held = '0;
        while (got <= len && cyc < 2000) begin
            if (got == abort_after) begin
                bus.rready = 1'b0;
                return;
            end
            bus.rready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
            if (mode == 0) begin
                checks++;
                if (bus.rvalid !== 1'b1) begin
                    errors++;
                    $display("FAIL %s back_to_back beat%0d: rvalid=%b required 1", name, got, bus.rvalid);
                end
            end
            if (bus.rvalid === 1'b1) begin
                if (held_v) begin
                    checks++;
                    if (bus.rdata !== held) begin
                        errors++;
                        $display("FAIL %s stall_stable beat%0d: rdata=%h required %h", name, got, bus.rdata, held);
                    end
                end
                if (bus.rready) begin
                    e = exp_q.pop_front();
                    checks++;
                    if (bus.rdata !== e.data || bus.rlast !== e.last || bus.rresp !== 2'b00) begin
                        errors++;
                        $display("FAIL %s beat%0d: rdata=%h rlast=%b rresp=%b required %h/%b/00",
                                 name, got, bus.rdata, bus.rlast, bus.rresp, e.data, e.last);
                    end
                    got++;
                    held_v = 1'b0;
                end else begin
                    held   = bus.rdata;
                    held_v = 1'b1;
                end
            end
            tick();
            cyc++;
        end
        bus.rready = 1'b0;
        checks++;
        if (got != len + 1 || bus.rvalid !== 1'b0 || bus.arready !== 1'b1) begin
            errors++;
            $display("FAIL %s read_done: beats=%0d rvalid=%b arready=%b required %0d/0/1",
                     name, got, bus.rvalid, bus.arready, len + 1);
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if ({bus.awready, bus.wready, bus.bvalid, bus.bresp, bus.arready, bus.rvalid, bus.rlast} !== 8'h00
            || bus.rdata !== 128'h0) begin
            errors++;
            $display("FAIL reset_outputs: aw=%b w=%b b=%b bresp=%b ar=%b r=%b rlast=%b required all 0",
                     bus.awready, bus.wready, bus.bvalid, bus.bresp, bus.arready, bus.rvalid, bus.rlast);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.awready !== 1'b0 || bus.arready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_early: awready=%b arready=%b required 0/0", bus.awready, bus.arready);
        end
        tick();
        checks++;
        if (bus.awready !== 1'b1 || bus.arready !== 1'b1 || bus.wready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: awready=%b arready=%b wready=%b required 1/1/0",
                     bus.awready, bus.arready, bus.wready);
        end
    endtask

    task automatic test_single();
        wbeat[0]     = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        wstrb_arr[0] = 16'hFFFF;
        axi_write(27'h0000040, 0, -1, 0, 2'b00, "single_wr");
        axi_read(27'h0000040, 0, 0, -1, "single_rd");
    endtask

    task automatic test_burst_strobe();
        fill_beats(3, 32'h1111_0000);
        axi_write(27'h0000100, 3, -1, 0, 2'b00, "burst_prefill");
        fill_beats(3, 32'hBEEF_0001);
        wstrb_arr[1] = 16'h000F;
        axi_write(27'h0000100, 3, -1, 0, 2'b00, "burst_strobe_wr");
        axi_read(27'h0000100, 3, 0, -1, "burst_strobe_rd");
    endtask

    task automatic test_backpressure();
        fill_beats(7, 32'hC0DE_0000);
        axi_write(27'h0001000, 7, -1, 5, 2'b00, "bp_write");
        axi_read(27'h0001000, 7, 1, -1, "bp_read");
    endtask

    task automatic test_wlast_error();
        fill_beats(2, 32'hE000_0000);
        axi_write(27'h0000300, 2, 1, 0, 2'b10, "wlast_early");
        fill_beats(2, 32'hF000_0000);
        wstrb_arr[1] = 16'h0000;
        axi_write(27'h0000300, 2, -1, 0, 2'b00, "wlast_ok");
        axi_read(27'h0000300, 2, 0, -1, "wlast_rd");
    endtask

    task automatic test_wrap_alias();
        fill_beats(1, 32'h7777_0000);
        axi_write(27'(DEPTH - 1) << 4, 1, -1, 0, 2'b00, "wrap_wr");
        axi_read(27'h0000000, 0, 0, -1, "wrap_word0");
        axi_read((27'(DEPTH - 1) << 4) + (27'd1 << (DEPTH_LOG2 + 4)), 1, 0, -1, "alias_rd");
    endtask

    task automatic test_reset_mid_burst();
        fill_beats(15, 32'h2222_0000);
        axi_write(27'h0002000, 15, -1, 0, 2'b00, "rst_prefill");
        axi_read(27'h0002000, 15, 0, 5, "rst_partial");
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.rvalid !== 1'b0 || bus.arready !== 1'b0 || bus.awready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: rvalid=%b arready=%b awready=%b required 0/0/0",
                     bus.rvalid, bus.arready, bus.awready);
        end
        exp_q.delete();
        tick();
        @(negedge clk);
        rst = 1'b1;
        tick();
        checks++;
        if (bus.arready !== 1'b1 || bus.rvalid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_release: arready=%b rvalid=%b required 1/0", bus.arready, bus.rvalid);
        end
        axi_read(27'h0002000, 15, 0, -1, "rst_reread");
        axi_read(27'h0000040, 0, 0, -1, "rst_mem_intact");
    endtask

    initial begin
        bus.awaddr = '0; bus.awlen = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b0;
        bus.araddr = '0; bus.arlen = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        test_reset();
        test_single();
        test_burst_strobe();
        test_backpressure();
        test_wlast_error();
        test_wrap_alias();
        test_reset_mid_burst();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: size=%0d required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
